// File: rtl/mem_byte_ctrl_if.sv
// Word-request / byte-RAM bus bundle for mem_byte_ctrl.
// slave = the controller; master = the CPU plus the byte RAM it faces.
interface mem_byte_ctrl_if;
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;
    logic [31:0] b_addr;
    logic        b_we;
    logic [7:0]  b_wdata;
    logic [7:0]  b_rdata;

    modport slave (
        input  req, rw, addr, wdata, b_rdata,
        output rdata, ready, err, busy, b_addr, b_we, b_wdata
    );

    modport master (
        output req, rw, addr, wdata, b_rdata,
        input  rdata, ready, err, busy, b_addr, b_we, b_wdata
    );
endinterface

// File: rtl/mem_byte_ctrl.sv
// Splits one 32-bit word request into four big-endian byte accesses on a byte RAM.
// Define MEM_ALIGN_CHECK_EN to also reject addresses that are not word aligned.
module mem_byte_ctrl #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic             clock,
    input  logic             reset,
    mem_byte_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic        err_q, err_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] rdata_q, rdata_d;

    logic [32:0] lastByte;
    logic        inRange;
    logic        legal;
    logic [7:0]  wByte;

    // Unsigned 33-bit sum so a wrapping address is caught as out of range.
    assign lastByte = {1'b0, bus.addr} + 33'd3;
    assign inRange  = lastByte < 33'(MEM_BYTES);

`ifdef MEM_ALIGN_CHECK_EN
    assign legal = inRange && (bus.addr[1:0] == 2'b00);
`else
    assign legal = inRange;
`endif

    always_comb begin
        wByte = 8'h00;
        case (idx_q)
            2'd0: wByte = wdata_q[31:24];
            2'd1: wByte = wdata_q[23:16];
            2'd2: wByte = wdata_q[15:8];
            2'd3: wByte = wdata_q[7:0];
            default: wByte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        err_d       = err_q;
        asm_d       = asm_q;
        rdata_d     = rdata_q;
        bus.b_addr  = 32'd0;
        bus.b_we    = 1'b0;
        bus.b_wdata = 8'h00;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    rw_d    = bus.rw;
                    idx_d   = 2'd0;
                    err_d   = !legal;
                    state_d = legal ? XFER : DONE;
                end
            end
            XFER: begin
                bus.b_addr  = addr_q + {30'd0, idx_q};
                bus.b_we    = !rw_q;
                bus.b_wdata = rw_q ? 8'h00 : wByte;
                if (rw_q) begin
                    asm_d = {asm_q[23:0], bus.b_rdata};
                end
                idx_d = idx_q + 2'd1;
                // The last byte goes straight into rdata so it is visible with ready.
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    if (rw_q) begin
                        rdata_d = {asm_q[23:0], bus.b_rdata};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            asm_q   <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = (state_q == DONE);
    assign bus.err   = (state_q == DONE) && err_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: doc/mem_byte_ctrl.md
# mem_byte_ctrl

Bus-interface stage between the CPU's MAR/MDR port and a byte-wide main memory. It accepts one 32-bit word read or write request and performs it as four sequential single-byte accesses in big-endian order. It then returns a one-cycle `ready` pulse. Sits directly downstream of the CPU control unit, in place of its direct word-wide `m_en`/`m_rw` memory access, and upstream of the byte RAM.

## Interface
- `MEM_BYTES`, 128: size of the attached byte memory; valid byte addresses are 0..MEM_BYTES-1.
- `clock`  input  1  single clock; all state changes on posedge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  1  request strobe; sampled only in IDLE.
- `rw`  input  1  1 = read, 0 = write (same encoding as CPU `m_rw`).
- `addr`  input  32  byte address of the word's MSB byte.
- `wdata`  input  32  write word.
- `rdata`  output  32  last completed read word.
- `ready`  output  1  one-cycle completion pulse.
- `err`  output  1  valid with `ready`: request rejected, no memory access made.
- `busy`  output  1  high whenever state != IDLE.
- `b_addr`  output  32  byte address to RAM.
- `b_we`  output  1  byte write enable.
- `b_wdata`  output  8  byte write data.
- `b_rdata`  input  8  byte read data; combinational from `b_addr`.

## Operation
- States: IDLE, XFER, DONE.
- IDLE, `req`=1 at a posedge:
  - Latch `addr`, `wdata`, `rw` into `addr_q`, `wdata_q`, `rw_q`.
  - Clear byte index `idx` to 0.
  - If the request is legal, go to XFER. Otherwise go to DONE with `err_q`=1.
- Illegal request: `addr` + 3 >= MEM_BYTES, evaluated as an unsigned 33-bit sum, so address wrap-around is illegal.
- XFER:
  - `b_addr` = `addr_q` + `idx`.
  - Byte `idx` maps to word bits [31-8*idx -: 8]; byte 0 is the MSB.
  - Write: `b_we`=1 and `b_wdata` = `wdata_q` byte `idx`.
  - Read: `b_we`=0; at each posedge, shift `b_rdata` into the assembly register.
  - `idx` increments each cycle. At the posedge with `idx`=3, go to DONE.
- DONE:
  - `ready`=1 for exactly one cycle; `err` = `err_q`.
  - On a successful read, `rdata` is loaded from the assembly register at the posedge entering DONE.
  - Go to IDLE at the next posedge.
- Outside XFER, `b_addr`=0, `b_we`=0 and `b_wdata`=0.
- `rdata` holds its value across writes, errors and idle time. It changes only on a successful read.
- `req`, `addr`, `wdata` and `rw` are ignored while `busy`=1.
- A requester must drop `req` in the `ready` cycle. If `req` is still high in the following IDLE cycle, a new transaction starts.

## Timing
- Reset values: `rdata`=0, `ready`=0, `err`=0, `busy`=0, `b_addr`=0, `b_we`=0, `b_wdata`=0, state=IDLE, `idx`=0.
- Legal request accepted at edge E0:
  - Bytes 0..3 are accessed in the cycles following E0..E3.
  - `ready` is high in the cycle following E4.
  - IDLE is re-entered at E5.
  - Total: 5 cycles per word; back-to-back throughput of one word per 6 cycles.
- Illegal request accepted at E0: `ready`=`err`=1 in the cycle after E0, IDLE at E1, no `b_we` pulse.
- RAM write timing: the RAM captures a byte on the posedge where `b_we`=1. Read data is used in the same cycle it is addressed.
- Reset mid-transaction:
  - Aborts immediately; outputs return to reset values at that posedge.
  - Bytes already written remain in RAM. No `ready` is issued for the aborted request.
- `reset` has priority over `req` in the same cycle.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `addr[1:0]` != 0 is also illegal: `err` path, no memory access.
  - The range check still applies.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Unaligned addresses are legal.
  - Only the range check produces `err`.

## Test plan
- Write then read, aligned:
  - Write 0x13221000 at `addr` 0x0C. The RAM must see bytes 0x13, 0x22, 0x10, 0x00 at addresses 0x0C..0x0F on four consecutive cycles.
  - Then read `addr` 0x0C. `rdata`=0x13221000 with `ready`=1, `err`=0, exactly 5 cycles after acceptance.
- Range boundary, MEM_BYTES=128:
  - Read at `addr` 124 succeeds.
  - Read at 125 gives `ready`=`err`=1 in 1 cycle, `b_we` never asserted, `rdata` unchanged.
  - Read at 0xFFFFFFFE (wrap) gives `err`.
- Alignment:
  - Write to `addr` 0x02 with the macro defined: `err`=1, RAM untouched.
  - Same write without the macro: bytes land at 0x02..0x05.
- Held request: hold `req`=1 for 20 cycles with a fixed read at 0x18. `ready` pulses every 6 cycles, and `busy` is low exactly one cycle between transactions.
- Reset mid-write: assert `reset` on the cycle byte 1 is written. Bytes 0–1 are updated, bytes 2–3 keep their old values, and all outputs are 0 on the next cycle with no `ready`.
- Ignore while busy: change `addr`, `rw` and `wdata` during XFER. The transaction completes with the originally latched values.
